cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Responder side of the cache-to-memory request protocol. The instruction cache and data cache raise read and write requests. This block arbitrates between them, issues one transaction at a time to the single-port RAM, and holds each requester's wait signal high until its transaction completes. It sits between the two cache front-ends and the RAM model/controller.

## Interface
- TIMEOUT, 64: maximum cycles one transaction may stay in service before it is aborted. Must be ≥ 2.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- iwait  out  1  1 = instruction request not yet satisfied.
- iload  out  32  instruction read data; valid when iREN=1 and iwait=0.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN when both are 1.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dwait  out  1  1 = data request not yet satisfied.
- dload  out  32  data read value; valid when dREN=1 and dwait=0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write value.
- ramload  in  32  RAM read value.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- err  out  1  sticky error flag.

## Operation
- States:
  - IDLE
  - ISERV (instruction transaction owns the RAM)
  - DSERV (data transaction owns the RAM)
- Registers:
  - state
  - last_d: 1 = the last completed transaction was data
  - tcnt: timeout counter, $clog2(TIMEOUT+1) bits
  - err
- Arbitration happens only in IDLE and is registered. The grant takes effect on the next edge.
  - Only the data side pending → DSERV.
  - Only iREN pending → ISERV.
  - Both pending → DSERV if last_d=0, ISERV if last_d=1. This alternates the two sides so neither starves.
- In IDLE, all RAM strobes are 0, iwait=1, dwait=1, iload=0, dload=0.
- ISERV:
  - ramREN=1, ramWEN=0, ramaddr=iaddr. Address is passed through combinationally, so it tracks live changes.
  - Completion: ramstate==ACCESS in a cycle with iREN=1. In that cycle iwait=0 and iload=ramload. Next state is IDLE and last_d←0.
- DSERV:
  - ramaddr=daddr and ramstore=dstore.
  - dWEN=1 → ramWEN=1, ramREN=0. Otherwise ramREN=dREN.
  - Completion: ramstate==ACCESS with (dREN|dWEN)=1. In that cycle dwait=0 and dload=ramload (dload is don't-care on writes). Next state is IDLE and last_d←1.
- The non-granted side always sees wait=1 and load=0.
- Withdrawal: if the owner drops its request (iREN=0 in ISERV, or dREN=dWEN=0 in DSERV), state goes to IDLE at the next edge. last_d is unchanged, strobes are 0 that cycle, and err is unchanged.
- Error: ramstate==ERROR while serving → owner's wait stays 1, err←1, state goes to IDLE at the next edge. The requester is re-arbitrated and retries.
- Timeout: tcnt clears on entry to a serve state and increments each serving cycle that does not complete. When tcnt reaches TIMEOUT-1 without completion, err←1 and state goes to IDLE.
- err clears only on RST.
- A request held high across completion is re-arbitrated in IDLE as a new transaction. Every transaction costs at least one IDLE cycle.

## Timing
- Reset values: state=IDLE, last_d=0, tcnt=0, err=0. Therefore iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- RST asserted mid-transaction: all strobes drop to 0 at the next edge and no completion is signalled. If RST is asserted in the same cycle as ramstate==ACCESS, wait is still deasserted combinationally in that cycle, but state returns to IDLE with last_d=0.
- Latency: request seen at edge N (in IDLE) → RAM strobes from cycle N+1. With RAM latency L (cycles of BUSY before ACCESS), wait falls in cycle N+1+L.
- Minimum request-to-hit is 2 cycles (L=0). Back-to-back same-side throughput is 1 transaction per (L+2) cycles.
- Outputs are combinational from state and inputs. Only state, last_d, tcnt and err are registered.

## Test plan
- Reset: hold RST 2 cycles with iREN=1 → iwait=1, dwait=1, ramREN=0, err=0 throughout. The first ISERV cycle follows the first non-reset edge.
- Instruction read: iREN=1, iaddr=0x40; RAM BUSY 2 cycles then ACCESS with ramload=0x8C010004 → ramaddr=0x40 for 3 cycles, iwait=0 and iload=0x8C010004 in the ACCESS cycle, state=IDLE next.
- Simultaneous: iREN=1, dWEN=1, daddr=0x100, dstore=0xDEADBEEF held, L=0 → data served first (ramWEN=1, ramstore=0xDEADBEEF), then instruction, then data again. Completions alternate D, I, D; neither side starves.
- Write priority: dREN=1 and dWEN=1 together → ramWEN=1, ramREN=0.
- Withdrawal: in ISERV, drop iREN after 1 cycle of BUSY → IDLE next edge, err=0, last_d unchanged.
- Error and timeout:
  - ramstate=ERROR during DSERV → dwait stays 1, err=1 sticky, re-arbitrated in IDLE.
  - With TIMEOUT=4 and ramstate held BUSY → abort after 4 serving cycles, err=1.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbitrates instruction/data cache requests onto a single-port RAM, one
// transaction at a time, with alternating priority, error and timeout abort.
module cache_mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int unsigned TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISERV, DSERV} state_e;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ram_state_e;

    state_e         state_q, state_d;
    logic           last_d_q, last_d_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic           err_q, err_d;

    ram_state_e rs;
    logic       dreq;
    logic       owner_req;
    logic       i_done;
    logic       d_done;

    assign rs     = ram_state_e'(ramstate);
    assign dreq   = dREN | dWEN;
    assign i_done = (state_q == ISERV) && iREN && (rs == RAM_ACCESS);
    assign d_done = (state_q == DSERV) && dreq && (rs == RAM_ACCESS);
    assign err    = err_q;

    always_comb begin
        iwait    = ~i_done;
        iload    = i_done ? ramload : '0;
        dwait    = ~d_done;
        dload    = d_done ? ramload : '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            ISERV: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            DSERV: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        tcnt_d    = tcnt_q;
        err_d     = err_q;
        owner_req = (state_q == ISERV) ? iREN : dreq;
        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                // Both pending: serve the side that did not complete last.
                if (dreq && (!iREN || !last_d_q)) begin
                    state_d = DSERV;
                end else if (iREN) begin
                    state_d = ISERV;
                end
            end
            ISERV, DSERV: begin
                if (i_done || d_done) begin
                    state_d  = IDLE;
                    last_d_d = (state_q == DSERV);
                end else if (!owner_req) begin
                    state_d = IDLE;
                end else if (rs == RAM_ERROR) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            tcnt_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            tcnt_q   <= tcnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench: stimulus pushes expected completions to a scoreboard that a
// negedge monitor pops whenever iwait or dwait falls.
module tb_cache_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    cache_mem_arbiter #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        side_d;
        logic        chk_data;
        logic [31:0] data;
    } resp_t;

    resp_t       sb[$];
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_bus(input string name, input logic ren, input logic wen,
                           input logic iw, input logic dw, input logic e);
        chk({name, ".ramREN"}, 32'(ramREN), 32'(ren));
        chk({name, ".ramWEN"}, 32'(ramWEN), 32'(wen));
        chk({name, ".iwait"},  32'(iwait),  32'(iw));
        chk({name, ".dwait"},  32'(dwait),  32'(dw));
        chk({name, ".err"},    32'(err),    32'(e));
    endtask

    task automatic push(input logic side_d, input logic chk_data, input logic [31:0] data);
        resp_t r;
        r.side_d   = side_d;
        r.chk_data = chk_data;
        r.data     = data;
        sb.push_back(r);
    endtask

    task automatic pop_chk(input logic side_d, input logic [31:0] load);
        resp_t r;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL sb_unexpected: completion on side_d=%0d got none expected", side_d);
            return;
        end
        r = sb.pop_front();
        chk("sb_side", 32'(side_d), 32'(r.side_d));
        if (r.chk_data) chk("sb_data", load, r.data);
    endtask

    always @(negedge CLK) begin
        if (iwait === 1'b0) pop_chk(1'b0, iload);
        if (dwait === 1'b0) pop_chk(1'b1, dload);
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic mid;
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        push(1'b0, 1'b1, 32'h8C01_0004);

        // Reset held two edges with iREN pending
        tick; mid; chk_bus("rst0", 0, 0, 1, 1, 0); chk("rst0.ramaddr", ramaddr, 32'h0);
        tick; RST = 1'b0;
        mid; chk_bus("rst1", 0, 0, 1, 1, 0); chk("rst1.ramstore", ramstore, 32'h0);

        // Instruction read, L=2
        tick; ramstate = BUSY;
        mid; chk_bus("ird_b0", 1, 0, 1, 1, 0); chk("ird_b0.ramaddr", ramaddr, 32'h40);
        tick;
        mid; chk_bus("ird_b1", 1, 0, 1, 1, 0); chk("ird_b1.ramaddr", ramaddr, 32'h40);
        tick; ramstate = ACCESS; ramload = 32'h8C01_0004;
        mid; chk_bus("ird_acc", 1, 0, 0, 1, 0); chk("ird_acc.ramaddr", ramaddr, 32'h40);
        tick; iREN = 1'b0; ramstate = FREE; ramload = '0;
        mid; chk_bus("ird_idle", 0, 0, 1, 1, 0);

        // Simultaneous requests, L=0: expect D, I, D
        tick; iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100;
        dstore = 32'hDEAD_BEEF; ramstate = ACCESS; ramload = 32'h1111_2222;
        push(1'b1, 1'b0, '0); push(1'b0, 1'b1, 32'h1111_2222); push(1'b1, 1'b0, '0);
        mid; chk_bus("sim_idle0", 0, 0, 1, 1, 0);
        tick;
        mid; chk_bus("sim_d1", 0, 1, 1, 0, 0);
        chk("sim_d1.ramstore", ramstore, 32'hDEAD_BEEF);
        chk("sim_d1.ramaddr", ramaddr, 32'h100);
        chk("sim_d1.iload", iload, 32'h0);
        tick;
        mid; chk_bus("sim_idle1", 0, 0, 1, 1, 0);
        tick;
        mid; chk_bus("sim_i", 1, 0, 0, 1, 0);
        chk("sim_i.ramaddr", ramaddr, 32'h80);
        chk("sim_i.dload", dload, 32'h0);
        tick;
        mid; chk_bus("sim_idle2", 0, 0, 1, 1, 0);
        tick;
        mid; chk_bus("sim_d2", 0, 1, 1, 0, 0);
        tick; iREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        mid; chk_bus("sim_idle3", 0, 0, 1, 1, 0);

        // Write wins over read
        tick; dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h1234_5678;
        ramstate = BUSY; push(1'b1, 1'b0, '0);
        tick;
        mid; chk_bus("wpri_busy", 0, 1, 1, 1, 0); chk("wpri.ramstore", ramstore, 32'h1234_5678);
        tick; ramstate = ACCESS;
        mid; chk_bus("wpri_acc", 0, 1, 1, 0, 0);
        tick; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;

        // Withdrawal in ISERV; last_d stays 1 so I wins the next tie
        tick; iREN = 1'b1; iaddr = 32'h44; daddr = 32'h300; ramstate = BUSY;
        tick;
        mid; chk_bus("wd_busy", 1, 0, 1, 1, 0);
        tick; iREN = 1'b0;
        mid; chk_bus("wd_drop", 0, 0, 1, 1, 0);
        tick; iREN = 1'b1; dREN = 1'b1; ramstate = FREE; push(1'b0, 1'b1, 32'hCAFE_0001);
        mid; chk_bus("wd_idle", 0, 0, 1, 1, 0);
        tick; ramstate = ACCESS; ramload = 32'hCAFE_0001;
        mid; chk_bus("wd_rearb", 1, 0, 0, 1, 0); chk("wd_rearb.ramaddr", ramaddr, 32'h44);

        // RAM error during DSERV, then retry
        tick; iREN = 1'b0; ramstate = FREE; push(1'b1, 1'b1, 32'h0BAD_F00D);
        mid; chk_bus("err_pre", 0, 0, 1, 1, 0);
        tick; ramstate = ERROR;
        mid; chk_bus("err_serv", 1, 0, 1, 1, 0); chk("err_serv.ramaddr", ramaddr, 32'h300);
        tick; ramstate = FREE;
        mid; chk_bus("err_idle", 0, 0, 1, 1, 1);
        tick; ramstate = ACCESS; ramload = 32'h0BAD_F00D;
        mid; chk_bus("err_retry", 1, 0, 1, 0, 1);
        tick; dREN = 1'b0; ramstate = FREE; ramload = '0;
        mid; chk_bus("err_sticky", 0, 0, 1, 1, 1);

        // Reset mid-transaction clears err and drops strobes
        tick; iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY;
        tick; RST = 1'b1;
        mid; chk_bus("rst_mid", 1, 0, 1, 1, 1);
        tick; RST = 1'b0;
        mid; chk_bus("rst_after", 0, 0, 1, 1, 0);

        // Timeout: four BUSY serving cycles then abort
        for (int k = 0; k < 4; k++) begin
            tick;
            mid; chk_bus($sformatf("tmo_%0d", k), 1, 0, 1, 1, 0);
        end
        tick;
        mid; chk_bus("tmo_abort", 0, 0, 1, 1, 1);
        tick; iREN = 1'b0;
        mid; chk_bus("tmo_drop", 0, 0, 1, 1, 1);
        tick;
        mid; chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
